// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared state codes, mux selects and opcode names for the calculator sequencer
package calc_pkg;

  localparam int CSW = 4;

  typedef enum logic [CSW-1:0] {
    IDLE   = 4'd0,
    WRITE1 = 4'd1,
    WRITE2 = 4'd2,
    READ   = 4'd3,
    EXEC   = 4'd4,
    OUTPUT = 4'd8
  } state_t;

  localparam logic [1:0] MUX_A   = 2'd3;
  localparam logic [1:0] MUX_B   = 2'd2;
  localparam logic [1:0] MUX_ALU = 2'd0;

  localparam int OP_ADD = 3;
  localparam int OP_SUB = 2;
  localparam int OP_AND = 1;
  localparam int OP_XOR = 0;

endpackage

// File: rtl/calc_op_latch.sv
// rtl/calc_op_latch.sv - captures opcode, addresses and accumulate count at start; counts passes down
module calc_op_latch #(
  parameter int AW  = 2,
  parameter int OPW = 2,
  parameter int CW  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           dec,
  input  logic [OPW-1:0] op,
  input  logic [AW-1:0]  src_a,
  input  logic [AW-1:0]  src_b,
  input  logic [AW-1:0]  dst,
  input  logic           acc_mode,
  input  logic [CW-1:0]  iter,
  output logic [OPW-1:0] op_q,
  output logic [AW-1:0]  src_a_q,
  output logic [AW-1:0]  src_b_q,
  output logic [AW-1:0]  dst_q,
  output logic           acc_q,
  output logic [CW-1:0]  count_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q   <= '0;
      acc_q   <= 1'b0;
      count_q <= '0;
    end else if (load) begin
      op_q    <= op;
      src_a_q <= src_a;
      src_b_q <= src_b;
      dst_q   <= dst;
      acc_q   <= acc_mode;
      count_q <= iter;
    end else if (dec) begin
      count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/calc_ctrl_seq.sv
// rtl/calc_ctrl_seq.sv - Moore control FSM for the register-file / ALU / output-mux calculator datapath
module calc_ctrl_seq
  import calc_pkg::*;
#(
  parameter int AW        = 2,
  parameter int OPW       = 2,
  parameter int NUM_OPS   = 4,
  parameter int CW        = 4,
  parameter bit HOLD_DONE = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic [OPW-1:0] op,
  input  logic [AW-1:0]  src_a,
  input  logic [AW-1:0]  src_b,
  input  logic [AW-1:0]  dst,
  input  logic           acc_mode,
  input  logic [CW-1:0]  iter,
  input  logic           ack,
  output logic [1:0]     s1,
  output logic [AW-1:0]  WA,
  output logic           WE,
  output logic [AW-1:0]  RAA,
  output logic [AW-1:0]  RAB,
  output logic           REA,
  output logic           REB,
  output logic [OPW-1:0] C,
  output logic           s2,
  output logic [3:0]     CS,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam logic [OPW:0] NUM_OPS_W = (OPW+1)'(NUM_OPS);

  state_t         cs;
  logic           err_q;
  logic           first_q;
  logic           load;
  logic           dec;
  logic           illegal_op;
  logic [OPW-1:0] op_q;
  logic [AW-1:0]  src_a_q;
  logic [AW-1:0]  src_b_q;
  logic [AW-1:0]  dst_q;
  logic           acc_q;
  logic [CW-1:0]  count_q;

  assign load       = (cs == IDLE) && go;
  assign dec        = (cs == EXEC) && acc_q && (count_q != '0);
  assign illegal_op = {1'b0, op_q} >= NUM_OPS_W;

  calc_op_latch #(.AW(AW), .OPW(OPW), .CW(CW)) u_latch (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .dec      (dec),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .dst      (dst),
    .acc_mode (acc_mode),
    .iter     (iter),
    .op_q     (op_q),
    .src_a_q  (src_a_q),
    .src_b_q  (src_b_q),
    .dst_q    (dst_q),
    .acc_q    (acc_q),
    .count_q  (count_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cs      <= IDLE;
      err_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      case (cs)
        IDLE: if (go) begin
          cs      <= WRITE1;
          err_q   <= 1'b0;
          first_q <= 1'b1;
        end
        WRITE1: cs <= WRITE2;
        WRITE2: cs <= READ;
        READ: begin
          if (illegal_op) begin
            err_q <= 1'b1;
            cs    <= OUTPUT;
          end else begin
            cs <= EXEC;
          end
        end
        // Later passes read the previous result back through port A.
        EXEC: begin
          first_q <= 1'b0;
          cs      <= dec ? READ : OUTPUT;
        end
        OUTPUT: if (!HOLD_DONE || ack) cs <= IDLE;
        default: cs <= IDLE;
      endcase
    end
  end

  always_comb begin
    s1   = '0;
    WA   = '0;
    WE   = 1'b0;
    RAA  = '0;
    RAB  = '0;
    REA  = 1'b0;
    REB  = 1'b0;
    C    = '0;
    s2   = 1'b0;
    done = 1'b0;
    err  = 1'b0;
    busy = (cs != IDLE);
    case (cs)
      WRITE1: begin
        s1 = MUX_A;
        WA = src_a_q;
        WE = 1'b1;
      end
      WRITE2: begin
        s1 = MUX_B;
        WA = src_b_q;
        WE = 1'b1;
      end
      READ: begin
        RAA = first_q ? src_a_q : dst_q;
        RAB = src_b_q;
        REA = 1'b1;
        REB = 1'b1;
      end
      EXEC: begin
        s1 = MUX_ALU;
        WA = dst_q;
        WE = 1'b1;
        C  = op_q;
      end
      OUTPUT: begin
        s2   = 1'b1;
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

  assign CS = cs;

endmodule

// File: tb/tb_calc_ctrl_seq.sv
// tb/tb_calc_ctrl_seq.sv - bench for calc_ctrl_seq: default instance and a 3-op hold-done instance
module tb_calc_ctrl_seq;

  typedef struct packed {
    logic [3:0] cs;
    logic       busy;
    logic [1:0] s1;
    logic [1:0] wa;
    logic       we;
    logic [1:0] raa;
    logic [1:0] rab;
    logic       rea;
    logic       reb;
    logic [1:0] c;
    logic       s2;
    logic       done;
    logic       err;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst0, rst1, go0, go1, ack, acc_mode;
  logic [1:0] op, src_a, src_b, dst;
  logic [3:0] iter;

  logic [1:0] s1_w [2];
  logic [1:0] wa_w [2];
  logic [1:0] raa_w [2];
  logic [1:0] rab_w [2];
  logic [1:0] c_w [2];
  logic       we_w [2];
  logic       rea_w [2];
  logic       reb_w [2];
  logic       s2_w [2];
  logic       busy_w [2];
  logic       done_w [2];
  logic       err_w [2];
  logic [3:0] cs_w [2];

  int n_chk = 0;
  int n_err = 0;

  obs_t exp_q[$];
  bit   ack_q[$];

  always #5 clk = ~clk;

  calc_ctrl_seq #(.AW(2), .OPW(2), .NUM_OPS(4), .CW(4), .HOLD_DONE(1'b0)) dut0 (
    .clk(clk), .rst(rst0), .go(go0), .op(op), .src_a(src_a), .src_b(src_b), .dst(dst),
    .acc_mode(acc_mode), .iter(iter), .ack(ack),
    .s1(s1_w[0]), .WA(wa_w[0]), .WE(we_w[0]), .RAA(raa_w[0]), .RAB(rab_w[0]),
    .REA(rea_w[0]), .REB(reb_w[0]), .C(c_w[0]), .s2(s2_w[0]), .CS(cs_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0])
  );

  calc_ctrl_seq #(.AW(2), .OPW(2), .NUM_OPS(3), .CW(4), .HOLD_DONE(1'b1)) dut1 (
    .clk(clk), .rst(rst1), .go(go1), .op(op), .src_a(src_a), .src_b(src_b), .dst(dst),
    .acc_mode(acc_mode), .iter(iter), .ack(ack),
    .s1(s1_w[1]), .WA(wa_w[1]), .WE(we_w[1]), .RAA(raa_w[1]), .RAB(rab_w[1]),
    .REA(rea_w[1]), .REB(reb_w[1]), .C(c_w[1]), .s2(s2_w[1]), .CS(cs_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1])
  );

  function automatic obs_t sample(int s);
    obs_t o;
    o.cs = cs_w[s];   o.busy = busy_w[s]; o.s1 = s1_w[s];   o.wa = wa_w[s];
    o.we = we_w[s];   o.raa = raa_w[s];   o.rab = rab_w[s]; o.rea = rea_w[s];
    o.reb = reb_w[s]; o.c = c_w[s];       o.s2 = s2_w[s];   o.done = done_w[s];
    o.err = err_w[s];
    return o;
  endfunction

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_obs(int s, obs_t e, string where);
    obs_t o = sample(s);
    chk({where, " cs"},   o.cs,   e.cs);
    chk({where, " busy"}, o.busy, e.busy);
    chk({where, " s1"},   o.s1,   e.s1);
    chk({where, " wa"},   o.wa,   e.wa);
    chk({where, " we"},   o.we,   e.we);
    chk({where, " raa"},  o.raa,  e.raa);
    chk({where, " rab"},  o.rab,  e.rab);
    chk({where, " rea"},  o.rea,  e.rea);
    chk({where, " reb"},  o.reb,  e.reb);
    chk({where, " c"},    o.c,    e.c);
    chk({where, " s2"},   o.s2,   e.s2);
    chk({where, " done"}, o.done, e.done);
    chk({where, " err"},  o.err,  e.err);
  endtask

  task automatic set_go(int s, logic v);
    if (s == 0) go0 = v;
    else go1 = v;
  endtask

  // Reference: a transaction is write A, write B, then READ/EXEC pairs
  // (one per pass), then OUTPUT; an illegal opcode stops after the first READ.
  task automatic build(int s, int o, int a, int b, int d, int acc, int it, int hold);
    obs_t e;
    int   passes = (acc != 0) ? it + 1 : 1;
    bit   illegal = (o >= ((s == 0) ? 4 : 3));
    exp_q.delete();
    ack_q.delete();
    e = '0; e.busy = 1; e.cs = 1; e.s1 = 3; e.wa = 2'(a); e.we = 1;
    exp_q.push_back(e); ack_q.push_back(1'($urandom));
    e = '0; e.busy = 1; e.cs = 2; e.s1 = 2; e.wa = 2'(b); e.we = 1;
    exp_q.push_back(e); ack_q.push_back(1'($urandom));
    for (int p = 0; p < passes; p++) begin
      e = '0; e.busy = 1; e.cs = 3; e.raa = 2'((p == 0) ? a : d); e.rab = 2'(b);
      e.rea = 1; e.reb = 1;
      exp_q.push_back(e); ack_q.push_back(1'($urandom));
      if (illegal) break;
      e = '0; e.busy = 1; e.cs = 4; e.s1 = 0; e.wa = 2'(d); e.we = 1; e.c = 2'(o);
      exp_q.push_back(e); ack_q.push_back(1'($urandom));
    end
    e = '0; e.busy = 1; e.cs = 8; e.s2 = 1; e.done = 1; e.err = illegal;
    if (s == 0) begin
      exp_q.push_back(e); ack_q.push_back(1'($urandom));
    end else begin
      for (int h = 0; h < hold; h++) begin
        exp_q.push_back(e); ack_q.push_back(h == hold - 1);
      end
    end
  endtask

  task automatic run_txn(int s, int o, int a, int b, int d, int acc, int it, int hold);
    string tag = $sformatf("d%0d op%0d acc%0d it%0d", s, o, acc, it);
    build(s, o, a, b, d, acc, it, hold);
    @(posedge clk); #1;
    op = 2'(o); src_a = 2'(a); src_b = 2'(b); dst = 2'(d);
    acc_mode = 1'(acc); iter = 4'(it); ack = 1'b0;
    set_go(s, 1'b1);
    @(negedge clk);
    check_obs(s, '0, {tag, " c0"});
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      set_go(s, 1'b0);
      op = 2'($urandom); src_a = 2'($urandom); src_b = 2'($urandom); dst = 2'($urandom);
      acc_mode = 1'($urandom); iter = 4'($urandom);
      ack = ack_q[i];
      @(negedge clk);
      check_obs(s, exp_q[i], $sformatf("%s c%0d", tag, i + 1));
    end
    @(posedge clk); #1;
    ack = 1'b0;
    @(negedge clk);
    check_obs(s, '0, {tag, " end"});
  endtask

  initial begin
    bit found;
    rst0 = 1; rst1 = 1; go0 = 0; go1 = 0; ack = 0; acc_mode = 0;
    op = 0; src_a = 0; src_b = 0; dst = 0; iter = 0;
    repeat (2) @(posedge clk);
    #1; rst0 = 0; rst1 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_obs(0, '0, $sformatf("reset d0 c%0d", i));
      check_obs(1, '0, $sformatf("reset d1 c%0d", i));
    end

    run_txn(0, calc_pkg::OP_ADD, 1, 2, 3, 0, 0, 1);
    run_txn(0, calc_pkg::OP_SUB, 1, 2, 3, 1, 2, 1);
    run_txn(0, calc_pkg::OP_AND, 2, 2, 0, 1, 0, 1);
    run_txn(1, 3, 1, 2, 3, 0, 0, 1);
    run_txn(1, calc_pkg::OP_XOR, 0, 1, 2, 0, 0, 6);
    run_txn(1, 3, 3, 0, 1, 1, 2, 2);
    run_txn(1, calc_pkg::OP_SUB, 3, 0, 1, 1, 1, 1);

    // go held high: one IDLE cycle between OUTPUT and the next WRITE1
    @(posedge clk); #1;
    op = 2'(calc_pkg::OP_ADD); src_a = 0; src_b = 1; dst = 2; acc_mode = 0; iter = 0;
    go0 = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (cs_w[0] == 4'd8) found = 1;
    end
    chk("b2b output reached", 4'(found), 4'd1);
    @(negedge clk);
    chk("b2b idle gap", cs_w[0], 4'd0);
    @(negedge clk);
    chk("b2b reaccept", cs_w[0], 4'd1);
    #1; go0 = 0;
    repeat (6) @(negedge clk);
    chk("b2b settle", cs_w[0], 4'd0);

    // reset while in EXEC
    @(posedge clk); #1;
    op = 0; src_a = 1; src_b = 2; dst = 3; acc_mode = 1; iter = 3; go1 = 1;
    @(posedge clk); #1; go1 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst exec pre cs", cs_w[1], 4'd4);
    rst1 = 1;
    @(posedge clk); #1; rst1 = 0;
    @(negedge clk);
    chk("rst exec cs", cs_w[1], 4'd0);
    chk("rst exec we", 4'(we_w[1]), 4'd0);

    // reset while holding OUTPUT with an error pending
    @(posedge clk); #1;
    op = 3; acc_mode = 0; ack = 0; go1 = 1;
    @(posedge clk); #1; go1 = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst hold pre cs", cs_w[1], 4'd8);
    chk("rst hold pre err", 4'(err_w[1]), 4'd1);
    rst1 = 1;
    @(posedge clk); #1; rst1 = 0;
    @(negedge clk);
    check_obs(1, '0, "rst hold");

    for (int n = 0; n < 12; n++) begin
      run_txn(0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3), 1);
      run_txn(1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
              $urandom_range(1, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/calc_ctrl_seq.md
Name: calc_ctrl_seq

Overview:
- Parametrised successor to the small-calculator control unit: a Moore FSM driving the register-file / ALU / output-mux datapath.
- New over the fixed 4-op sequencer:
  - run-time operand and destination addresses
  - configurable register-file depth and opcode width
  - accumulate mode that re-runs the ALU N times, feeding the result back
  - illegal-opcode error flag
  - optional done-hold handshake with ack
- Sits between the switch/button input logic and the datapath; CS drives the 7-seg state display.

Parameters:
- AW, 2, register-file address width (2**AW registers).
- OPW, 2, opcode / ALU control width.
- NUM_OPS, 4, number of legal opcodes (0..NUM_OPS-1); must be <= 2**OPW.
- CW, 4, accumulate-iteration counter width.
- HOLD_DONE, 0, 1 = hold OUTPUT until ack; 0 = OUTPUT lasts one cycle.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- go  in  1  start request; sampled only in IDLE.
- op  in  OPW  operation code.
- src_a  in  AW  address written with operand A, read as ALU port A.
- src_b  in  AW  address written with operand B, read as ALU port B.
- dst  in  AW  result address.
- acc_mode  in  1  1 = accumulate: repeat with RAA=dst.
- iter  in  CW  extra repetitions in accumulate mode.
- ack  in  1  releases OUTPUT when HOLD_DONE=1.
- s1  out  2  MUX1 select: 3 = operand A input, 2 = operand B input, 0 = ALU result.
- WA  out  AW  write address.
- WE  out  1  write enable.
- RAA  out  AW  read address A.
- RAB  out  AW  read address B.
- REA  out  1  read enable A.
- REB  out  1  read enable B.
- C  out  OPW  ALU control.
- s2  out  1  MUX2 select, 1 = present result.
- CS  out  4  current-state code.
- busy  out  1  cs != IDLE.
- done  out  1  result valid.
- err  out  1  illegal opcode, valid with done.

Behaviour:
- Reset:
  - On a rst-high edge, cs <= IDLE regardless of state, including mid-operation or while holding OUTPUT.
  - Latched op/src_a/src_b/dst/acc/count are cleared to 0.
- Outputs: pure Moore decode of cs and the latched registers. Every output is 0 in IDLE, so the post-reset value of all outputs is 0 and CS=0.
- State codes (CS): IDLE=0, WRITE1=1, WRITE2=2, READ=3, EXEC=4, OUTPUT=8. Codes 5–7 and 9–15 are illegal; an illegal code goes to IDLE on the next edge.
- IDLE:
  - go=1 -> WRITE1.
  - On the same edge, latch op, src_a, src_b, dst, acc_mode, and count <= iter.
  - Inputs are ignored outside IDLE.
- WRITE1: s1=3, WA=src_a_q, WE=1 -> WRITE2.
- WRITE2: s1=2, WA=src_b_q, WE=1 -> READ. If src_a==src_b, B overwrites A; no check.
- READ:
  - RAA = src_a_q on the first pass, dst_q on later passes. RAB=src_b_q, REA=REB=1.
  - If op_q >= NUM_OPS: set err_q, go to OUTPUT, no EXEC write.
  - Otherwise -> EXEC.
- EXEC:
  - s1=0, WA=dst_q, WE=1, C=op_q.
  - If acc_q=1 and count!=0: count decrements, go back to READ.
  - Otherwise -> OUTPUT.
- OUTPUT:
  - s2=1, done=1, err=err_q.
  - HOLD_DONE=0: -> IDLE next edge.
  - HOLD_DONE=1: stay until ack=1, then -> IDLE. ack outside OUTPUT is ignored.
- Latency: for a go edge at cycle k, done rises at k+5 + 2*(acc ? iter : 0). Error path: done at k+4.
- Back-to-back: go held high re-accepts after exactly one IDLE cycle.
- iter=0 with acc_mode=1 behaves exactly as a single pass.
- err_q clears on the next IDLE->WRITE1 transition or on rst.

Decomposition:
- Package calc_pkg holds:
  - state localparams and the CS width
  - the s1 select codes (MUX_A=3, MUX_B=2, MUX_ALU=0)
  - default opcode values ADD=3, SUB=2, AND=1, XOR=0
- One natural sub-module, calc_op_latch: the operand/opcode/count capture register with decrement. The FSM and output decode remain in calc_ctrl_seq.

Test Plan:
- Reset then idle (defaults): rst=1 for 2 cycles, go=0 -> all outputs 0, CS=0, busy=0 for 10 cycles.
- Single ADD: op=3, src_a=1, src_b=2, dst=3, go pulse at cycle 0.
  - CS sequence 1,2,3,4,8,0 on cycles 1–6.
  - EXEC: WA=3, WE=1, C=3.
  - done=1 only at cycle 5.
- Accumulate: op=2, dst=3, acc_mode=1, iter=2.
  - CS sequence 1,2,3,4,3,4,3,4,8.
  - RAA=1 on the first READ, 3 on the later READs; done at cycle 9.
- Illegal op (NUM_OPS=3): op=3 -> CS 1,2,3,8; no EXEC WE pulse; done=1 and err=1 at cycle 4. The next legal op clears err.
- Done hold (HOLD_DONE=1):
  - ack=0 for 5 cycles -> CS stays 8 with done=1.
  - ack=1 -> IDLE next edge.
  - rst asserted in EXEC -> CS=0 and WE=0 on the following cycle.
